alu_uart_interface: RTL and testbench
=====================================

// Module: alu_uart_interface
// PURPOSE
//   Sequencer between UART RX/TX and the combinational ALU. Collects three received bytes
//   (operand one, operand two, opcode) and drives them onto the ALU inputs. Captures the
//   ALU result and launches one UART TX transfer with it. A watchdog discards incomplete
//   frames.
// PARAMETERS
//   N_BITS          8    data width of operands, ALU result and UART byte
//   N_BITS_OP       6    opcode width; taken from rx byte bits [N_BITS_OP-1:0]
//   TIMEOUT_CYCLES  1000 max idle cycles between bytes of one frame; 0 disables watchdog
// PORTS
//   i_clk         in   1          system clock, rising edge
//   i_rst_n       in   1          asynchronous active-low reset
//   i_rx_data     in   N_BITS     received byte, valid when i_rx_done=1
//   i_rx_done     in   1          one-cycle pulse: new byte on i_rx_data
//   i_alu_result  in   N_BITS     o_alu of ALU, combinational from o_data_*/o_operator
//   i_tx_done     in   1          one-cycle pulse: UART TX finished current byte
//   o_data_one    out  N_BITS     ALU operand one (held)
//   o_data_two    out  N_BITS     ALU operand two (held)
//   o_operator    out  N_BITS_OP  ALU opcode (held)
//   o_tx_data     out  N_BITS     byte to transmit (held)
//   o_tx_start    out  1          one-cycle pulse: start TX of o_tx_data
//   o_busy        out  1          1 in any state other than WAIT_A
//   o_frame_err   out  1          one-cycle pulse: frame dropped by watchdog
// BEHAVIOUR
//   - Reset (async on i_rst_n=0): state=WAIT_A, all outputs 0, watchdog counter 0.
//     Reset mid-frame or mid-TX abandons the frame; no o_tx_start afterwards.
//   - FSM states: WAIT_A, WAIT_B, WAIT_OP, CALC, WAIT_TX. All outputs are registered.
//   - WAIT_A: on i_rx_done, latch i_rx_data into o_data_one and go to WAIT_B.
//   - WAIT_B: on i_rx_done, latch i_rx_data into o_data_two and go to WAIT_OP.
//   - WAIT_OP: on i_rx_done, latch i_rx_data[N_BITS_OP-1:0] into o_operator and go to CALC.
//     Upper opcode bits are ignored.
//   - CALC (exactly 1 cycle): latch o_tx_data<=i_alu_result, set o_tx_start<=1, go to WAIT_TX.
//     Timing: with i_rx_done (opcode) at edge T, o_tx_start=1 and o_tx_data are valid
//     in cycle T+2 only.
//   - WAIT_TX: wait for i_tx_done, then go to WAIT_A. i_tx_done in any other state is ignored.
//   - i_rx_done in CALC/WAIT_TX: byte dropped, no state change.
//   - o_data_one/o_data_two/o_operator hold their values until overwritten by the next
//     frame. They are not cleared after TX.
//   - Watchdog, active in WAIT_B and WAIT_OP only:
//     - Counter clears on state entry and on every i_rx_done; otherwise increments.
//     - When counter = TIMEOUT_CYCLES-1 with no i_rx_done that cycle: go to WAIT_A and
//       pulse o_frame_err for 1 cycle. Latched operands are kept.
//     - i_rx_done in the same cycle as expiry wins: byte accepted, no error.
//     - Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
//   - All data paths are unsigned bit copies. No arithmetic happens in this block.
// TESTING
//   1. A=0x05, B=0x03, op=0x20 (with ALU attached): o_tx_data=0x08, o_tx_start high for
//      exactly 1 cycle at T+2; i_tx_done -> o_busy=0 next cycle.
//   2. A=0x80, B=0x01, op=0x22: o_tx_data=0x7F. Then op byte 0xE0 in the next frame:
//      o_operator=0x20.
//   3. TIMEOUT_CYCLES=16: send A only, idle 16 cycles -> o_frame_err pulse, state WAIT_A;
//      then a full frame A=0x0F, B=0xF0, op=0x25 -> o_tx_data=0xFF.
//   4. Byte arriving on the exact expiry cycle: accepted, o_frame_err stays 0.
//   5. Extra i_rx_done pulses during WAIT_TX: no state change, no second o_tx_start;
//      next frame processed normally.
//   6. Assert i_rst_n=0 in WAIT_OP and again in WAIT_TX: all outputs 0 immediately
//      (async). After release, o_tx_start stays 0 until a new full frame arrives.

Source files
------------

// File: rtl/alu_uart_interface.sv
// alu_uart_interface
// Collects a three-byte frame from the UART receiver: operand one, operand two, then
// opcode. It holds those bytes on the ALU inputs, captures the ALU result one cycle
// later, and launches a single UART transmit with it. A watchdog drops frames that
// stall between bytes.
module alu_uart_interface #(
   parameter int N_BITS         = 8,
   parameter int N_BITS_OP      = 6,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [N_BITS-1:0]    i_rx_data,
   input  logic                 i_rx_done,
   input  logic [N_BITS-1:0]    i_alu_result,
   input  logic                 i_tx_done,
   output logic [N_BITS-1:0]    o_data_one,
   output logic [N_BITS-1:0]    o_data_two,
   output logic [N_BITS_OP-1:0] o_operator,
   output logic [N_BITS-1:0]    o_tx_data,
   output logic                 o_tx_start,
   output logic                 o_busy,
   output logic                 o_frame_err
);

   // The watchdog counter must be able to hold TIMEOUT_CYCLES. It keeps one bit
   // even when the watchdog is disabled, so the logic stays well formed.
   localparam int             WD_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit             WD_EN   = (TIMEOUT_CYCLES > 0);
   localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [WD_W-1:0] WD_MAX  = '1;

   typedef enum logic [2:0] {
      S_WAIT_A,
      S_WAIT_B,
      S_WAIT_OP,
      S_CALC,
      S_WAIT_TX
   } state_t;

   state_t                state_q, state_d;
   logic [N_BITS-1:0]     data_one_q, data_one_d;
   logic [N_BITS-1:0]     data_two_q, data_two_d;
   logic [N_BITS_OP-1:0]  operator_q, operator_d;
   logic [N_BITS-1:0]     tx_data_q, tx_data_d;
   logic                  tx_start_q, tx_start_d;
   logic                  busy_q, busy_d;
   logic                  frame_err_q, frame_err_d;
   logic [WD_W-1:0]       wd_q, wd_d;
   logic                  wd_expired;

   // An expiry counts only when no byte arrives in that cycle, so a late byte wins.
   assign wd_expired = WD_EN && (wd_q == WD_LAST) && !i_rx_done;

   // Next-state logic: frame sequencing, datapath capture and watchdog bookkeeping.
   always_comb begin
      state_d     = state_q;
      data_one_d  = data_one_q;
      data_two_d  = data_two_q;
      operator_d  = operator_q;
      tx_data_d   = tx_data_q;
      tx_start_d  = 1'b0;
      frame_err_d = 1'b0;
      wd_d        = '0;

      case (state_q)
         S_WAIT_A: begin
            if (i_rx_done) begin
               data_one_d = i_rx_data;
               state_d    = S_WAIT_B;
            end
         end
         S_WAIT_B: begin
            if (i_rx_done) begin
               data_two_d = i_rx_data;
               state_d    = S_WAIT_OP;
            end else if (wd_expired) begin
               frame_err_d = 1'b1;
               state_d     = S_WAIT_A;
            end else begin
               wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
            end
         end
         S_WAIT_OP: begin
            if (i_rx_done) begin
               operator_d = i_rx_data[N_BITS_OP-1:0];
               state_d    = S_CALC;
            end else if (wd_expired) begin
               frame_err_d = 1'b1;
               state_d     = S_WAIT_A;
            end else begin
               wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
            end
         end
         S_CALC: begin
            // The ALU inputs have been stable for one cycle, so its output is settled.
            tx_data_d  = i_alu_result;
            tx_start_d = 1'b1;
            state_d    = S_WAIT_TX;
         end
         S_WAIT_TX: begin
            if (i_tx_done) begin
               state_d = S_WAIT_A;
            end
         end
         default: begin
            state_d = S_WAIT_A;
         end
      endcase

      busy_d = (state_d != S_WAIT_A);
   end

   // Register all state and outputs. Reset abandons any frame in progress.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_WAIT_A;
         data_one_q  <= '0;
         data_two_q  <= '0;
         operator_q  <= '0;
         tx_data_q   <= '0;
         tx_start_q  <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         wd_q        <= '0;
      end else begin
         state_q     <= state_d;
         data_one_q  <= data_one_d;
         data_two_q  <= data_two_d;
         operator_q  <= operator_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         busy_q      <= busy_d;
         frame_err_q <= frame_err_d;
         wd_q        <= wd_d;
      end
   end

   assign o_data_one  = data_one_q;
   assign o_data_two  = data_two_q;
   assign o_operator  = operator_q;
   assign o_tx_data   = tx_data_q;
   assign o_tx_start  = tx_start_q;
   assign o_busy      = busy_q;
   assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: a table of known frames, randomized frames checked
// against an arithmetic reference, and hand sequences for watchdog and reset cases.
module tb_alu_uart_interface;

   localparam int NB  = 8;
   localparam int NOP = 6;
   localparam int TO  = 16;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [NB-1:0]  rx_data = '0;
   logic           rx_done = 1'b0;
   logic [NB-1:0]  alu_result;
   logic           tx_done = 1'b0;
   logic [NB-1:0]  data_one, data_two, tx_data;
   logic [NOP-1:0] operator;
   logic           tx_start, busy, frame_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Reference ALU: plain arithmetic on the opcode values.
   function automatic logic [NB-1:0] alu_ref(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                             input logic [NOP-1:0] op);
      logic signed [NB-1:0] sa;
      sa = a;
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h03:   return sa >>> b;
         6'h02:   return a >> b;
         6'h27:   return ~(a | b);
         default: return '0;
      endcase
   endfunction

   // Combinational ALU attached to the sequencer's held operand outputs.
   assign alu_result = alu_ref(data_one, data_two, operator);

   alu_uart_interface #(
      .N_BITS(NB), .N_BITS_OP(NOP), .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
      .i_alu_result(alu_result), .i_tx_done(tx_done),
      .o_data_one(data_one), .o_data_two(data_two), .o_operator(operator),
      .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy), .o_frame_err(frame_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rx(input logic [NB-1:0] b);
      rx_data = b;
      rx_done = 1'b1;
      step();
      rx_done = 1'b0;
   endtask

   task automatic pulse_tx();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_one"},   32'(data_one),  32'h0);
      check({tag, "_two"},   32'(data_two),  32'h0);
      check({tag, "_op"},    32'(operator),  32'h0);
      check({tag, "_txd"},   32'(tx_data),   32'h0);
      check({tag, "_start"}, 32'(tx_start),  32'h0);
      check({tag, "_busy"},  32'(busy),      32'h0);
      check({tag, "_ferr"},  32'(frame_err), 32'h0);
   endtask

   // Full frame, with optional stray rx bytes while waiting for the transmitter.
   task automatic run_frame(input logic [NB-1:0] a, input logic [NB-1:0] b,
                            input logic [NB-1:0] op, input logic [NB-1:0] exp_tx,
                            input logic [NOP-1:0] exp_op, input int extra);
      pulse_rx(a);
      check("busy_after_a", 32'(busy), 32'h1);
      check("data_one", 32'(data_one), 32'(a));
      pulse_rx(b);
      check("data_two", 32'(data_two), 32'(b));
      pulse_rx(op);
      check("operator", 32'(operator), 32'(exp_op));
      check("start_early", 32'(tx_start), 32'h0);
      step();
      check("start_t2", 32'(tx_start), 32'h1);
      check("tx_data", 32'(tx_data), 32'(exp_tx));
      if (extra > 0) begin
         for (int i = 0; i < extra; i++) begin
            pulse_rx(8'($urandom));
            check("start_extra_rx", 32'(tx_start), 32'h0);
            check("busy_extra_rx", 32'(busy), 32'h1);
            check("one_extra_rx", 32'(data_one), 32'(a));
         end
      end else begin
         step();
         check("start_one_cycle", 32'(tx_start), 32'h0);
      end
      check("busy_wait_tx", 32'(busy), 32'h1);
      pulse_tx();
      check("busy_after_tx", 32'(busy), 32'h0);
      check("ferr_frame", 32'(frame_err), 32'h0);
      $display("frame a=%02h b=%02h op=%02h tx=%02h expected=%02h", a, b, op, tx_data, exp_tx);
   endtask

   typedef struct {
      logic [NB-1:0]  a;
      logic [NB-1:0]  b;
      logic [NB-1:0]  op;
      logic [NB-1:0]  exp_tx;
      logic [NOP-1:0] exp_op;
   } vec_t;

   vec_t           vecs[9];
   logic [NOP-1:0] opcodes[8];

   initial begin
      logic [NB-1:0] ra, rb, rop;

      vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08, 6'h20};
      vecs[1] = '{8'h80, 8'h01, 8'h22, 8'h7F, 6'h22};
      vecs[2] = '{8'h12, 8'h34, 8'hE0, 8'h46, 6'h20};
      vecs[3] = '{8'h0F, 8'hF0, 8'h25, 8'hFF, 6'h25};
      vecs[4] = '{8'hF0, 8'h3C, 8'h24, 8'h30, 6'h24};
      vecs[5] = '{8'hAA, 8'hFF, 8'h26, 8'h55, 6'h26};
      vecs[6] = '{8'h81, 8'h02, 8'h03, 8'hE0, 6'h03};
      vecs[7] = '{8'h81, 8'h02, 8'h42, 8'h20, 6'h02};
      vecs[8] = '{8'h0F, 8'hF0, 8'hA7, 8'h00, 6'h27};
      opcodes = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      #2 rst_n = 1'b1;
      step();
      check("busy_idle", 32'(busy), 32'h0);

      // Table-driven frames.
      for (int i = 0; i < 9; i++) begin
         run_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_tx, vecs[i].exp_op, i % 3);
      end

      // Watchdog expiry in WAIT_B, then a normal frame.
      pulse_rx(8'h5A);
      for (int i = 0; i < TO - 1; i++) begin
         step();
         check("wd_b_no_err", 32'(frame_err), 32'h0);
      end
      step();
      check("wd_b_err", 32'(frame_err), 32'h1);
      check("wd_b_idle", 32'(busy), 32'h0);
      check("wd_b_keep_one", 32'(data_one), 32'h5A);
      step();
      check("wd_b_err_pulse", 32'(frame_err), 32'h0);
      $display("timeout in WAIT_B after %0d idle cycles", TO);
      run_frame(8'h0F, 8'hF0, 8'h25, 8'hFF, 6'h25, 0);

      // Watchdog expiry in WAIT_OP keeps both operands.
      pulse_rx(8'h11);
      pulse_rx(8'h22);
      for (int i = 0; i < TO - 1; i++) step();
      check("wd_op_no_err_early", 32'(frame_err), 32'h0);
      step();
      check("wd_op_err", 32'(frame_err), 32'h1);
      check("wd_op_idle", 32'(busy), 32'h0);
      check("wd_op_keep_two", 32'(data_two), 32'h22);
      $display("timeout in WAIT_OP after %0d idle cycles", TO);

      // A byte on the exact expiry cycle is accepted.
      pulse_rx(8'h09);
      for (int i = 0; i < TO - 1; i++) step();
      pulse_rx(8'h06);
      check("edge_no_err", 32'(frame_err), 32'h0);
      check("edge_two", 32'(data_two), 32'h06);
      check("edge_busy", 32'(busy), 32'h1);
      pulse_rx(8'h20);
      step();
      check("edge_start", 32'(tx_start), 32'h1);
      check("edge_tx", 32'(tx_data), 32'h0F);
      step();
      pulse_tx();
      check("edge_done", 32'(busy), 32'h0);
      $display("byte on expiry cycle accepted tx=%02h", tx_data);

      // Asynchronous reset while in WAIT_OP.
      pulse_rx(8'h33);
      pulse_rx(8'h44);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("rst_op");
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("rst_op_no_start", 32'(tx_start), 32'h0);
         check("rst_op_idle", 32'(busy), 32'h0);
      end
      pulse_rx(8'h20);
      check("rst_op_new_a", 32'(data_one), 32'h20);
      check("rst_op_busy", 32'(busy), 32'h1);
      step();
      check("rst_op_still_no_start", 32'(tx_start), 32'h0);
      pulse_tx();
      check("tx_done_ignored", 32'(busy), 32'h1);
      pulse_rx(8'h05);
      pulse_rx(8'h20);
      step();
      check("rst_op_frame_start", 32'(tx_start), 32'h1);
      check("rst_op_frame_tx", 32'(tx_data), 32'h25);
      step();
      pulse_tx();
      $display("reset in WAIT_OP then frame tx=%02h", tx_data);

      // Asynchronous reset while in WAIT_TX, right as the start pulse is high.
      pulse_rx(8'h01);
      pulse_rx(8'h02);
      pulse_rx(8'h20);
      step();
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("rst_tx");
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("rst_tx_no_start", 32'(tx_start), 32'h0);
      end
      pulse_tx();
      check("rst_tx_idle", 32'(busy), 32'h0);
      $display("reset in WAIT_TX, no start afterwards");

      // Randomized frames against the reference model.
      for (int i = 0; i < 20; i++) begin
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         rop = {2'($urandom), opcodes[$urandom_range(0, 7)]};
         run_frame(ra, rb, rop, alu_ref(ra, rb, rop[NOP-1:0]), rop[NOP-1:0],
                   int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
